sparc_exu_yreg_bank: RTL



---
 rtl/sparc_exu_yreg_bank.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sparc_exu_yreg_bank.sv
// rtl/sparc_exu_yreg_bank.sv - per-thread Y register bank with MULScc shift and serial shift sequencer
// Optional read bypass of pending W/G writes: define YREG_BYPASS_EN.
module sparc_exu_yreg_bank #(
  parameter int NTHR  = 4,
  parameter int WIDTH = 32,
  parameter int TW    = 2,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             arst_l,
  input  logic             se,
  input  logic [WIDTH-1:0] wr_w_data,
  input  logic [NTHR-1:0]  wr_w_en,
  input  logic [WIDTH-1:0] wr_g_data,
  input  logic [NTHR-1:0]  wr_g_en,
  input  logic [NTHR-1:0]  shift_en,
  input  logic             shift_bit,
  input  logic [TW-1:0]    rd_thr,
  output logic [WIDTH-1:0] rd_data,
  output logic [NTHR-1:0]  lsb_l,
  input  logic             seq_start,
  input  logic [TW-1:0]    seq_thr,
  input  logic [CW-1:0]    seq_cnt,
  input  logic             seq_bit,
  input  logic             seq_bit_vld,
  output logic             seq_bit_rdy,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_abort,
  output logic             wr_collide
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SHIFT = 1'b1;
  localparam logic [TW:0]   NTHR_W   = (TW+1)'(NTHR);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

  logic [WIDTH-1:0] y_q [NTHR];
  logic [WIDTH-1:0] wr_w_data_q;
  logic [0:0]       state_q;
  logic [TW-1:0]    thr_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             abort_q;

  logic [NTHR-1:0]  thr_sel;
  logic             hit_wg;
  logic             hit_any;
  logic             seq_fire;
  logic             start_ok;
  logic [CW-1:0]    cnt_clamp;
  logic             unused_se;

  assign unused_se = se;

  always_comb begin
    thr_sel = '0;
    for (int i = 0; i < NTHR; i++) begin
      thr_sel[i] = (thr_q == TW'(i));
    end
  end

  // Any higher-priority update of the latched thread stalls the sequencer; only writes abort it.
  assign seq_busy    = (state_q == ST_SHIFT);
  assign hit_wg      = |((wr_w_en | wr_g_en) & thr_sel);
  assign hit_any     = |((wr_w_en | wr_g_en | shift_en) & thr_sel);
  assign seq_bit_rdy = seq_busy & ~hit_any;
  assign seq_fire    = seq_bit_rdy & seq_bit_vld;
  assign start_ok    = seq_start & ~seq_busy & ({1'b0, seq_thr} < NTHR_W);
  assign cnt_clamp   = (seq_cnt > CNT_MAX) ? CNT_MAX : seq_cnt;
  assign seq_done    = done_q;
  assign seq_abort   = abort_q;
  assign wr_collide  = arst_l & (|(wr_w_en & wr_g_en));

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      wr_w_data_q <= '0;
      for (int i = 0; i < NTHR; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      wr_w_data_q <= wr_w_data;
      for (int i = 0; i < NTHR; i++) begin
        if (wr_w_en[i]) begin
          y_q[i] <= wr_w_data_q;
        end else if (wr_g_en[i]) begin
          y_q[i] <= wr_g_data;
        end else if (shift_en[i]) begin
          y_q[i] <= {shift_bit, y_q[i][WIDTH-1:1]};
        end else if (seq_fire && thr_sel[i]) begin
          y_q[i] <= {seq_bit, y_q[i][WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= ST_IDLE;
      thr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (start_ok) begin
          if (cnt_clamp == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q <= ST_SHIFT;
            thr_q   <= seq_thr;
            cnt_q   <= cnt_clamp;
          end
        end
      end else begin
        if (hit_wg) begin
          state_q <= ST_IDLE;
          abort_q <= 1'b1;
        end else if (seq_fire) begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (arst_l && ({1'b0, rd_thr} < NTHR_W)) begin
`ifdef YREG_BYPASS_EN
      if (wr_w_en[rd_thr]) begin
        rd_data = wr_w_data_q;
      end else if (wr_g_en[rd_thr]) begin
        rd_data = wr_g_data;
      end else begin
        rd_data = y_q[rd_thr];
      end
`else
      rd_data = y_q[rd_thr];
`endif
    end
  end

  always_comb begin
    lsb_l = '0;
    for (int i = 0; i < NTHR; i++) begin
      lsb_l[i] = ~y_q[i][0];
    end
  end

endmodule
